// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the RV64I-subset core: decodes IR, steps the
// shared datapath one state per cycle and runs the imem/dmem valid/ready handshakes.

package opcodes;
  localparam logic [6:0] TYPE_R    = 7'b0110011;
  localparam logic [6:0] TYPE_I    = 7'b0010011;
  localparam logic [6:0] TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] TYPE_S    = 7'b0100011;
  localparam logic [6:0] TYPE_SB   = 7'b1100011;
  localparam logic [6:0] TYPE_JAL  = 7'b1101111;
  localparam logic [6:0] TYPE_JALR = 7'b1100111;
  localparam logic [6:0] TYPE_LUI  = 7'b0110111;
  localparam logic [6:0] TYPE_SYS  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SRL   = 4'd5,
    ALU_SRA   = 4'd6,
    ALU_PASSB = 4'd7
  } alu_op_e;
endpackage

module multicycle_ctrl
  import opcodes::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                alu_eq,
  input  logic                alu_lt,
  output logic                imem_req,
  input  logic                imem_ready,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [1:0]          dmem_size,
  output logic                dmem_unsigned,
  input  logic                dmem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                aluout_write,
  output logic [2:0]          imm_sel,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                halt,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_ACC,
    S_LOAD_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_HALT
  } state_e;

  state_e  state_q, state_d;
  logic    halt_q, halt_d;
  logic    illegal_q, illegal_d;
  alu_op_e alu_op_sel;
  logic    trap, trap_illegal;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_store;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign is_store = (opcode == TYPE_S);
  // Register numbers are routed by the datapath; the controller never looks at them.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign alu_op  = ALU_OP_W'(alu_op_sel);
  assign halt    = halt_q;
  assign illegal = illegal_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    halt_d        = halt_q;
    illegal_d     = illegal_q;
    trap          = 1'b0;
    trap_illegal  = 1'b0;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_size     = 2'd0;
    dmem_unsigned = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_op_sel    = ALU_ADD;
    aluout_write  = 1'b0;
    imm_sel       = 3'd0;
    reg_write     = 1'b0;
    wb_sel        = 2'd0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative old_pc+imm: branch/JAL target ready in ALUOut for the next state.
        alu_src_a    = 2'd1;
        alu_src_b    = 2'd1;
        imm_sel      = (opcode == TYPE_JAL) ? 3'd4 : 3'd2;
        aluout_write = 1'b1;
        case (opcode)
          TYPE_R:            state_d = S_EXEC_R;
          TYPE_I, TYPE_LUI:  state_d = S_EXEC_I;
          TYPE_LOAD, TYPE_S: state_d = S_MEM_ADDR;
          TYPE_SB:           state_d = S_BRANCH;
          TYPE_JAL:          state_d = S_JUMP;
          TYPE_JALR: begin
            if (f3 == 3'b000) state_d = S_JUMP;
            else begin trap = 1'b1; trap_illegal = 1'b1; end
          end
          TYPE_SYS: trap = 1'b1;
          default:  begin trap = 1'b1; trap_illegal = 1'b1; end
        endcase
      end
      S_EXEC_R: begin
        aluout_write = 1'b1;
        state_d      = S_ALU_WB;
        case ({f7, f3})
          {7'b0000000, 3'b000}: alu_op_sel = ALU_ADD;
          {7'b0100000, 3'b000}: alu_op_sel = ALU_SUB;
          {7'b0000000, 3'b001}: alu_op_sel = ALU_SLL;
          {7'b0000000, 3'b010}: alu_op_sel = ALU_SLT;
          {7'b0000000, 3'b111}: alu_op_sel = ALU_AND;
          default: begin
            aluout_write = 1'b0;
            trap         = 1'b1;
            trap_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_I: begin
        alu_src_b    = 2'd1;
        aluout_write = 1'b1;
        state_d      = S_ALU_WB;
        if (opcode == TYPE_LUI) begin
          alu_src_a  = 2'd2;
          imm_sel    = 3'd3;
          alu_op_sel = ALU_PASSB;
        end else begin
          // f7[6:1] is checked, f7[0] is shamt[5] on RV64.
          case (f3)
            3'b000: alu_op_sel = ALU_ADD;
            3'b010: alu_op_sel = ALU_SLT;
            3'b001: begin
              alu_op_sel = ALU_SLL;
              if (f7[6:1] != 6'b000000) begin trap = 1'b1; trap_illegal = 1'b1; end
            end
            3'b101: begin
              if (f7[6:1] == 6'b000000)      alu_op_sel = ALU_SRL;
              else if (f7[6:1] == 6'b010000) alu_op_sel = ALU_SRA;
              else begin trap = 1'b1; trap_illegal = 1'b1; end
            end
            default: begin trap = 1'b1; trap_illegal = 1'b1; end
          endcase
          if (trap) aluout_write = 1'b0;
        end
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'd0;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_b     = 2'd1;
        imm_sel       = is_store ? 3'd1 : 3'd0;
        dmem_size     = f3[1:0];
        dmem_unsigned = f3[2];
        if (is_store && f3[2]) begin
          trap         = 1'b1;
          trap_illegal = 1'b1;
        end else begin
          aluout_write = 1'b1;
          state_d      = S_MEM_ACC;
        end
      end
      S_MEM_ACC: begin
        dmem_req      = 1'b1;
        dmem_we       = is_store;
        dmem_size     = f3[1:0];
        dmem_unsigned = f3[2];
        if (dmem_ready) state_d = is_store ? S_FETCH : S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_op_sel = ALU_SUB;
        state_d    = S_FETCH;
        case (f3)
          3'b000:  pc_write = alu_eq;
          3'b001:  pc_write = !alu_eq;
          3'b100:  pc_write = alu_lt;
          3'b101:  pc_write = !alu_lt;
          default: begin trap = 1'b1; trap_illegal = 1'b1; end
        endcase
        pc_src = pc_write ? 2'd1 : 2'd0;
      end
      S_JUMP: begin
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
        if (opcode == TYPE_JAL) begin
          pc_src = 2'd1;
        end else begin
          pc_src    = 2'd2;
          alu_src_b = 2'd1;
        end
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase

    if (trap) begin
      state_d   = S_HALT;
      halt_d    = 1'b1;
      illegal_d = trap_illegal;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_FETCH;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected per-cycle
// control vector, a negedge monitor pops and compares it against the DUT outputs.

module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       aluout_write;
    logic [2:0] imm_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic [1:0] dmem_size;
    logic       dmem_unsigned;
    logic       halt;
    logic       illegal;
  } exp_t;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_SD    = 32'h0020B823;
  localparam logic [31:0] I_LBU   = 32'h0000C283;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_BGE   = 32'h0020D463;
  localparam logic [31:0] I_JAL   = 32'h010000EF;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_SRAI  = 32'h4030D293;
  localparam logic [31:0] I_BADR  = 32'h4020F1B3;
  localparam logic [31:0] I_BREAK = 32'h00100073;
  localparam logic [31:0] I_UNK   = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, alu_eq, alu_lt, imem_ready, dmem_ready;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, dmem_unsigned, ir_write, pc_write;
  logic        aluout_write, reg_write, halt, illegal;
  logic [1:0]  dmem_size, pc_src, alu_src_a, alu_src_b, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  imm_sel;

  multicycle_ctrl #(.ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_eq(alu_eq), .alu_lt(alu_lt),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_unsigned(dmem_unsigned), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .aluout_write(aluout_write), .imm_sel(imm_sel), .reg_write(reg_write),
    .wb_sel(wb_sel), .halt(halt), .illegal(illegal)
  );

  exp_t act;
  assign act = {imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                aluout_write, imm_sel, reg_write, wb_sel, dmem_req, dmem_we,
                dmem_size, dmem_unsigned, halt, illegal};

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin : mon
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  function automatic exp_t fetch(input bit rdy);
    exp_t e = '0;
    e.imem_req = 1'b1;
    e.ir_write = rdy;
    e.pc_write = rdy;
    return e;
  endfunction

  function automatic exp_t dec(input bit jal);
    exp_t e = '0;
    e.alu_src_a    = 2'd1;
    e.alu_src_b    = 2'd1;
    e.imm_sel      = jal ? 3'd4 : 3'd2;
    e.aluout_write = 1'b1;
    return e;
  endfunction

  function automatic exp_t alu(input logic [1:0] a, input logic [1:0] b,
                               input logic [3:0] op, input logic [2:0] imm, input bit aw);
    exp_t e = '0;
    e.alu_src_a    = a;
    e.alu_src_b    = b;
    e.alu_op       = op;
    e.imm_sel      = imm;
    e.aluout_write = aw;
    return e;
  endfunction

  function automatic exp_t wb(input logic [1:0] sel);
    exp_t e = '0;
    e.reg_write = 1'b1;
    e.wb_sel    = sel;
    return e;
  endfunction

  function automatic exp_t maddr(input bit st, input logic [2:0] f3);
    exp_t e = alu(2'd0, 2'd1, 4'd0, st ? 3'd1 : 3'd0, 1'b1);
    e.dmem_size     = f3[1:0];
    e.dmem_unsigned = f3[2];
    return e;
  endfunction

  function automatic exp_t macc(input bit st, input logic [2:0] f3);
    exp_t e = '0;
    e.dmem_req      = 1'b1;
    e.dmem_we       = st;
    e.dmem_size     = f3[1:0];
    e.dmem_unsigned = f3[2];
    return e;
  endfunction

  function automatic exp_t br(input bit taken);
    exp_t e = alu(2'd0, 2'd0, 4'd1, 3'd0, 1'b0);
    e.pc_write = taken;
    e.pc_src   = taken ? 2'd1 : 2'd0;
    return e;
  endfunction

  function automatic exp_t jump(input bit jalr);
    exp_t e = jalr ? alu(2'd0, 2'd1, 4'd0, 3'd0, 1'b0) : '0;
    e.reg_write = 1'b1;
    e.wb_sel    = 2'd2;
    e.pc_write  = 1'b1;
    e.pc_src    = jalr ? 2'd2 : 2'd1;
    return e;
  endfunction

  function automatic exp_t halted(input bit ill);
    exp_t e = '0;
    e.halt    = 1'b1;
    e.illegal = ill;
    return e;
  endfunction

  // Drive one cycle of inputs just after the edge and queue what the DUT must show.
  task automatic cyc(input logic [31:0] ins, input bit imr, input bit dmr,
                     input bit eq, input bit lt, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    instr      = ins;
    imem_ready = imr;
    dmem_ready = dmr;
    alu_eq     = eq;
    alu_lt     = lt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    alu_eq = 1'b0; alu_lt = 1'b0;
    cyc('0, 0, 0, 0, 0, fetch(0), "reset_0");
    cyc('0, 0, 0, 0, 0, fetch(0), "reset_1");
    rst_n = 1'b1;

    // ADD, zero wait; stray readies in later cycles must be ignored.
    cyc(I_ADD, 1, 0, 0, 0, fetch(1), "add_fetch");
    cyc(I_ADD, 1, 1, 0, 0, dec(0), "add_decode");
    cyc(I_ADD, 1, 1, 0, 0, alu(0, 0, 4'd0, 3'd0, 1), "add_exec");
    cyc(I_ADD, 1, 1, 0, 0, wb(2'd0), "add_wb");

    // LW with one imem wait and three dmem waits.
    cyc(I_LW, 0, 0, 0, 0, fetch(0), "lw_fetch_wait");
    cyc(I_LW, 1, 0, 0, 0, fetch(1), "lw_fetch");
    cyc(I_LW, 0, 0, 0, 0, dec(0), "lw_decode");
    cyc(I_LW, 0, 0, 0, 0, maddr(0, 3'b010), "lw_addr");
    for (int i = 0; i < 3; i++) cyc(I_LW, 0, 0, 0, 0, macc(0, 3'b010), "lw_acc_wait");
    cyc(I_LW, 0, 1, 0, 0, macc(0, 3'b010), "lw_acc_ready");
    cyc(I_LW, 0, 0, 0, 0, wb(2'd1), "lw_wb");

    // SD zero wait: 4 cycles.
    cyc(I_SD, 1, 0, 0, 0, fetch(1), "sd_fetch");
    cyc(I_SD, 0, 0, 0, 0, dec(0), "sd_decode");
    cyc(I_SD, 0, 0, 0, 0, maddr(1, 3'b011), "sd_addr");
    cyc(I_SD, 0, 1, 0, 0, macc(1, 3'b011), "sd_acc");

    // LBU zero wait: 5 cycles, zero-extend flag.
    cyc(I_LBU, 1, 0, 0, 0, fetch(1), "lbu_fetch");
    cyc(I_LBU, 0, 0, 0, 0, dec(0), "lbu_decode");
    cyc(I_LBU, 0, 0, 0, 0, maddr(0, 3'b100), "lbu_addr");
    cyc(I_LBU, 0, 1, 0, 0, macc(0, 3'b100), "lbu_acc");
    cyc(I_LBU, 0, 0, 0, 0, wb(2'd1), "lbu_wb");

    // Branches.
    cyc(I_BNE, 1, 0, 0, 0, fetch(1), "bne_eq_fetch");
    cyc(I_BNE, 0, 0, 0, 0, dec(0), "bne_eq_decode");
    cyc(I_BNE, 0, 0, 1, 0, br(0), "bne_eq_not_taken");
    cyc(I_BNE, 1, 0, 1, 0, fetch(1), "bne_ne_fetch");
    cyc(I_BNE, 0, 0, 0, 0, dec(0), "bne_ne_decode");
    cyc(I_BNE, 0, 0, 0, 0, br(1), "bne_ne_taken");
    cyc(I_BGE, 1, 0, 0, 0, fetch(1), "bge_fetch");
    cyc(I_BGE, 0, 0, 0, 0, dec(0), "bge_decode");
    cyc(I_BGE, 0, 0, 0, 1, br(0), "bge_lt_not_taken");

    // Jumps.
    cyc(I_JAL, 1, 0, 0, 0, fetch(1), "jal_fetch");
    cyc(I_JAL, 0, 0, 0, 0, dec(1), "jal_decode");
    cyc(I_JAL, 0, 0, 0, 0, jump(0), "jal_jump");
    cyc(I_JALR, 1, 0, 0, 0, fetch(1), "jalr_fetch");
    cyc(I_JALR, 0, 0, 0, 0, dec(0), "jalr_decode");
    cyc(I_JALR, 0, 0, 0, 0, jump(1), "jalr_jump");

    // LUI and SRAI through EXEC_I.
    cyc(I_LUI, 1, 0, 0, 0, fetch(1), "lui_fetch");
    cyc(I_LUI, 0, 0, 0, 0, dec(0), "lui_decode");
    cyc(I_LUI, 0, 0, 0, 0, alu(2, 1, 4'd7, 3'd3, 1), "lui_exec");
    cyc(I_LUI, 0, 0, 0, 0, wb(2'd0), "lui_wb");
    cyc(I_SRAI, 1, 0, 0, 0, fetch(1), "srai_fetch");
    cyc(I_SRAI, 0, 0, 0, 0, dec(0), "srai_decode");
    cyc(I_SRAI, 0, 0, 0, 0, alu(0, 1, 4'd6, 3'd0, 1), "srai_exec");
    cyc(I_SRAI, 0, 0, 0, 0, wb(2'd0), "srai_wb");

    // Illegal R-type: halts with illegal, stuck until reset.
    cyc(I_BADR, 1, 0, 0, 0, fetch(1), "badr_fetch");
    cyc(I_BADR, 0, 0, 0, 0, dec(0), "badr_decode");
    cyc(I_BADR, 0, 0, 0, 0, '0, "badr_exec");
    for (int i = 0; i < 3; i++) cyc(I_BADR, 1, 1, 1, 1, halted(1), "badr_halt");
    rst_n = 1'b0;
    cyc('0, 0, 0, 0, 0, fetch(0), "badr_reset");
    rst_n = 1'b1;

    // BREAK: halt without illegal.
    cyc(I_BREAK, 1, 0, 0, 0, fetch(1), "brk_fetch");
    cyc(I_BREAK, 0, 0, 0, 0, dec(0), "brk_decode");
    cyc(I_BREAK, 1, 1, 0, 0, halted(0), "brk_halt_0");
    cyc(I_BREAK, 1, 1, 0, 0, halted(0), "brk_halt_1");
    rst_n = 1'b0;
    cyc('0, 0, 0, 0, 0, fetch(0), "brk_reset");
    rst_n = 1'b1;

    // Unknown opcode traps straight from DECODE.
    cyc(I_UNK, 1, 0, 0, 0, fetch(1), "unk_fetch");
    cyc(I_UNK, 0, 0, 0, 0, dec(0), "unk_decode");
    cyc(I_UNK, 0, 0, 0, 0, halted(1), "unk_halt");
    rst_n = 1'b0;
    cyc('0, 0, 0, 0, 0, fetch(0), "unk_reset");
    rst_n = 1'b1;

    // Reset during a store's MEM_ACC abandons the request.
    cyc(I_SD, 1, 0, 0, 0, fetch(1), "sdr_fetch");
    cyc(I_SD, 0, 0, 0, 0, dec(0), "sdr_decode");
    cyc(I_SD, 0, 0, 0, 0, maddr(1, 3'b011), "sdr_addr");
    cyc(I_SD, 0, 0, 0, 0, macc(1, 3'b011), "sdr_acc_wait");
    rst_n = 1'b0;
    cyc(I_SD, 0, 0, 0, 0, fetch(0), "sdr_req_dropped");
    rst_n = 1'b1;
    cyc(I_ADD, 0, 0, 0, 0, fetch(0), "sdr_refetch_wait");
    cyc(I_ADD, 1, 0, 0, 0, fetch(1), "sdr_refetch");
    cyc(I_ADD, 0, 0, 0, 0, dec(0), "sdr_next_decode");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
